// File: rtl/z80_bus_pkg.sv
// Shared types and constants for the Z80 bus responder: FSM states,
// decoded machine-cycle types and the idle data-bus value.
package z80_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } bus_state_e;

  typedef enum logic [2:0] {
    CYC_NONE = 3'd0,
    CYC_MRD  = 3'd1,
    CYC_MWR  = 3'd2,
    CYC_IORD = 3'd3,
    CYC_IOWR = 3'd4,
    CYC_INTA = 3'd5
  } cycle_e;

  localparam logic [7:0] BUS_IDLE_DATA = 8'hFF;

endpackage

// File: rtl/z80_cycle_decode.sv
// Combinational Z80 strobe-to-cycle-type decoder; refresh cycles decode as NONE.
module z80_cycle_decode
  import z80_bus_pkg::*;
(
  input  logic   m1_n_i,
  input  logic   mreq_n_i,
  input  logic   iorq_n_i,
  input  logic   rd_n_i,
  input  logic   wr_n_i,
  input  logic   rfsh_n_i,
  output cycle_e cyc_o
);

  always_comb begin
    cyc_o = CYC_NONE;
    if (!mreq_n_i && rfsh_n_i && !rd_n_i) begin
      cyc_o = CYC_MRD;
    end else if (!mreq_n_i && rfsh_n_i && !wr_n_i) begin
      cyc_o = CYC_MWR;
    end else if (!iorq_n_i && !m1_n_i) begin
      cyc_o = CYC_INTA;
    end else if (!iorq_n_i && !rd_n_i) begin
      cyc_o = CYC_IORD;
    end else if (!iorq_n_i && !wr_n_i) begin
      cyc_o = CYC_IOWR;
    end else begin
      cyc_o = CYC_NONE;
    end
  end

endmodule

// File: rtl/z80_bus_responder.sv
// Z80 bus responder: forwards memory cycles to a req/ack backing store with
// WAIT_n stretching and serves I/O and INTA cycles. Option: Z80_BUS_IO_PORT_EN.
module z80_bus_responder
  import z80_bus_pkg::*;
#(
  parameter int         ADDR_W       = 16,
  parameter logic [7:0] INT_VECTOR   = 8'hFF,
  parameter logic [7:0] IO_PORT_ADDR = 8'h00
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [15:0]       z_addr,
  input  logic [7:0]        z_dout,
  input  logic              z_m1_n,
  input  logic              z_mreq_n,
  input  logic              z_iorq_n,
  input  logic              z_rd_n,
  input  logic              z_wr_n,
  input  logic              z_rfsh_n,
  output logic [7:0]        z_din,
  output logic              z_wait_n,
  output logic              z_int_n,
  output logic              z_nmi_n,
  output logic              z_busrq_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
`ifdef Z80_BUS_IO_PORT_EN
  input  logic [7:0]        gpio_in,
  output logic [7:0]        gpio_out,
`endif
  input  logic              irq
);

  cycle_e            cyc_s;
  bus_state_e        state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              wait_n_q, wait_n_d;
  logic              int_n_q;
  logic [7:0]        gpio_q, gpio_d;
  logic              port_hit_s;

  z80_cycle_decode u_decode (
    .m1_n_i   (z_m1_n),
    .mreq_n_i (z_mreq_n),
    .iorq_n_i (z_iorq_n),
    .rd_n_i   (z_rd_n),
    .wr_n_i   (z_wr_n),
    .rfsh_n_i (z_rfsh_n),
    .cyc_o    (cyc_s)
  );

`ifdef Z80_BUS_IO_PORT_EN
  assign port_hit_s = (z_addr[7:0] == IO_PORT_ADDR);
  assign gpio_out   = gpio_q;
`else
  // Without the port every I/O access misses; the comparison is kept inert.
  logic unused_io_s;
  assign unused_io_s = ^IO_PORT_ADDR;
  assign port_hit_s  = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 8'h00;
      rdata_q  <= BUS_IDLE_DATA;
      wait_n_q <= 1'b1;
      int_n_q  <= 1'b1;
      gpio_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      wait_n_q <= wait_n_d;
      int_n_q  <= ~irq;
      gpio_q   <= gpio_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    wait_n_d = wait_n_q;
    gpio_d   = gpio_q;
    case (state_q)
      ST_IDLE: begin
        case (cyc_s)
          CYC_MRD, CYC_MWR: begin
            addr_d   = z_addr[ADDR_W-1:0];
            wdata_d  = z_dout;
            we_d     = (cyc_s == CYC_MWR);
            req_d    = 1'b1;
            wait_n_d = 1'b0;
            state_d  = ST_BUSY;
          end
          CYC_INTA: begin
            rdata_d = INT_VECTOR;
            state_d = ST_DONE;
          end
          CYC_IORD: begin
`ifdef Z80_BUS_IO_PORT_EN
            rdata_d = port_hit_s ? gpio_in : BUS_IDLE_DATA;
`else
            rdata_d = BUS_IDLE_DATA;
`endif
            state_d = ST_DONE;
          end
          CYC_IOWR: begin
            if (port_hit_s) begin
              gpio_d = z_dout;
            end else begin
              gpio_d = gpio_q;
            end
            state_d = ST_DONE;
          end
          default: state_d = ST_IDLE;
        endcase
      end
      // The request is held until ack even if the core abandons the cycle.
      ST_BUSY: begin
        if (mem_ack) begin
          req_d    = 1'b0;
          wait_n_d = 1'b1;
          if (!we_q) begin
            rdata_d = mem_rdata;
          end else begin
            rdata_d = rdata_q;
          end
          state_d = ST_DONE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (z_mreq_n && z_iorq_n) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign z_din     = (!z_rd_n || (!z_iorq_n && !z_m1_n)) ? rdata_q : BUS_IDLE_DATA;
  assign z_wait_n  = wait_n_q;
  assign z_int_n   = int_n_q;
  assign z_nmi_n   = 1'b1;
  assign z_busrq_n = 1'b1;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_z80_bus_responder.sv
// Directed self-checking bench for z80_bus_responder (default and
// Z80_BUS_IO_PORT_EN builds).
module tb_z80_bus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] z_addr;
  logic [7:0]  z_dout;
  logic        z_m1_n, z_mreq_n, z_iorq_n, z_rd_n, z_wr_n, z_rfsh_n;
  logic [7:0]  z_din;
  logic        z_wait_n, z_int_n, z_nmi_n, z_busrq_n;
  logic        mem_req, mem_we, mem_ack, irq;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [7:0]  gpio_in, gpio_out;
  int          checks = 0;
  int          errors = 0;
  int          wait_cnt;

  always #5 clk = ~clk;

  z80_bus_responder dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .z_addr    (z_addr),
    .z_dout    (z_dout),
    .z_m1_n    (z_m1_n),
    .z_mreq_n  (z_mreq_n),
    .z_iorq_n  (z_iorq_n),
    .z_rd_n    (z_rd_n),
    .z_wr_n    (z_wr_n),
    .z_rfsh_n  (z_rfsh_n),
    .z_din     (z_din),
    .z_wait_n  (z_wait_n),
    .z_int_n   (z_int_n),
    .z_nmi_n   (z_nmi_n),
    .z_busrq_n (z_busrq_n),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
`ifdef Z80_BUS_IO_PORT_EN
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
`endif
    .irq       (irq)
  );

`ifndef Z80_BUS_IO_PORT_EN
  assign gpio_out = 8'h00;
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    z_m1_n = 1'b1; z_mreq_n = 1'b1; z_iorq_n = 1'b1;
    z_rd_n = 1'b1; z_wr_n = 1'b1; z_rfsh_n = 1'b1;
  endtask

  // Called right after the strobe-capturing edge; ack is raised in req cycle ack_at+1.
  task automatic serve(input int ack_at, input logic [7:0] rd, output int cnt);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (z_wait_n === 1'b1) break;
      cnt++;
      mem_ack   = (i == ack_at);
      mem_rdata = rd;
      tick();
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = 8'h00; irq = 1'b0;
    z_addr = 16'h0000; z_dout = 8'h00; gpio_in = 8'h00;
    idle_bus();
    tick(); tick();
    rst = 1'b0;
    tick();
    check_eq("rst_req", mem_req, 1'b0);
    check_eq("rst_we", mem_we, 1'b0);
    check_eq("rst_addr", mem_addr, 16'h0000);
    check_eq("rst_wdata", mem_wdata, 8'h00);
    check_eq("rst_wait", z_wait_n, 1'b1);
    check_eq("rst_int", z_int_n, 1'b1);
    check_eq("rst_nmi", z_nmi_n, 1'b1);
    check_eq("rst_busrq", z_busrq_n, 1'b1);
    check_eq("rst_gpio", gpio_out, 8'h00);
    z_rd_n = 1'b0;
    #1 check_eq("rst_rdata", z_din, 8'hFF);
    z_rd_n = 1'b1;
    #1 check_eq("din_idle", z_din, 8'hFF);

    // Memory read, ack in the fourth request cycle.
    z_addr = 16'h1234; z_mreq_n = 1'b0; z_rd_n = 1'b0;
    tick();
    check_eq("mrd_req", mem_req, 1'b1);
    check_eq("mrd_addr", mem_addr, 16'h1234);
    check_eq("mrd_we", mem_we, 1'b0);
    serve(3, 8'h3E, wait_cnt);
    check_eq("mrd_wait_cycles", wait_cnt, 4);
    check_eq("mrd_req_drop", mem_req, 1'b0);
    check_eq("mrd_din", z_din, 8'h3E);
    tick();
    check_eq("mrd_no_double", mem_req, 1'b0);
    idle_bus();
    tick();

    // OUT (00h),5Ah then IN A,(00h).
    z_addr = 16'h0000; z_dout = 8'h5A; z_iorq_n = 1'b0; z_wr_n = 1'b0;
    tick();
    check_eq("iowr_wait", z_wait_n, 1'b1);
    check_eq("iowr_req", mem_req, 1'b0);
    idle_bus();
    tick();
    gpio_in = 8'hC3; z_iorq_n = 1'b0; z_rd_n = 1'b0;
    tick();
`ifdef Z80_BUS_IO_PORT_EN
    check_eq("gpio_out", gpio_out, 8'h5A);
    check_eq("iord_din", z_din, 8'hC3);
`else
    check_eq("iord_din", z_din, 8'hFF);
`endif
    check_eq("iord_req", mem_req, 1'b0);
    idle_bus();
    tick();

    // Memory write, immediate ack.
    z_addr = 16'h8000; z_dout = 8'hA5; z_mreq_n = 1'b0; z_wr_n = 1'b0;
    tick();
    check_eq("mwr_we", mem_we, 1'b1);
    check_eq("mwr_wdata", mem_wdata, 8'hA5);
    check_eq("mwr_addr", mem_addr, 16'h8000);
    serve(0, 8'h99, wait_cnt);
    check_eq("mwr_wait_cycles", wait_cnt, 1);
    check_eq("mwr_req_drop", mem_req, 1'b0);
    idle_bus();
    tick();

    // Interrupt request and acknowledge.
    irq = 1'b1;
    #1 check_eq("int_before_edge", z_int_n, 1'b1);
    tick();
    check_eq("int_asserted", z_int_n, 1'b0);
    z_m1_n = 1'b0; z_iorq_n = 1'b0;
    tick();
    check_eq("inta_din", z_din, 8'hFF);
    check_eq("inta_req", mem_req, 1'b0);
    check_eq("inta_wait", z_wait_n, 1'b1);
    idle_bus(); irq = 1'b0;
    tick();
    check_eq("int_release", z_int_n, 1'b1);

    // Refresh cycle is ignored.
    z_mreq_n = 1'b0; z_rfsh_n = 1'b0;
    tick(); tick();
    check_eq("rfsh_req", mem_req, 1'b0);
    check_eq("rfsh_wait", z_wait_n, 1'b1);
    idle_bus();
    tick();

    // Reset mid-BUSY then a stale ack.
    z_addr = 16'h4321; z_mreq_n = 1'b0; z_rd_n = 1'b0;
    tick();
    check_eq("rb_req", mem_req, 1'b1);
    rst = 1'b1; idle_bus();
    tick();
    rst = 1'b0;
    check_eq("rb_req_drop", mem_req, 1'b0);
    check_eq("rb_wait", z_wait_n, 1'b1);
    mem_ack = 1'b1; mem_rdata = 8'h77;
    tick();
    mem_ack = 1'b0;
    tick();
    check_eq("stale_req", mem_req, 1'b0);
    check_eq("stale_wait", z_wait_n, 1'b1);
    z_rd_n = 1'b0;
    #1 check_eq("stale_rdata", z_din, 8'hFF);
    z_rd_n = 1'b1;

    // Abort: strobes dropped while BUSY, request held until ack.
    z_addr = 16'h0042; z_mreq_n = 1'b0; z_rd_n = 1'b0;
    tick();
    idle_bus();
    tick(); tick();
    check_eq("abort_req_held", mem_req, 1'b1);
    check_eq("abort_wait", z_wait_n, 1'b0);
    mem_ack = 1'b1; mem_rdata = 8'h4C;
    tick();
    mem_ack = 1'b0;
    check_eq("abort_req_drop", mem_req, 1'b0);
    check_eq("abort_wait_rel", z_wait_n, 1'b1);
    tick();
    z_addr = 16'h0100; z_dout = 8'h11; z_mreq_n = 1'b0; z_wr_n = 1'b0;
    tick();
    check_eq("abort_next_req", mem_req, 1'b1);
    check_eq("abort_next_addr", mem_addr, 16'h0100);
    serve(1, 8'h00, wait_cnt);
    check_eq("abort_next_wait", wait_cnt, 2);
    idle_bus();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
